// File: rtl/serial_divider32_pkg.sv
// rtl/serial_divider32_pkg.sv - shared ALU constants and divider state encoding
package serial_divider32_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int COUNT_BITS    = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Quotient reported for a divide by zero.
    localparam logic [DEFAULT_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_subtract33.sv
// rtl/div_subtract33.sv - ripple-borrow subtractor (a + ~b + 1) for one divide step
module div_subtract33 #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N-1:0] b_inv;
    logic         carry;

    assign b_inv = ~b;

    // Full-adder chain with carry-in 1; a borrow is the absence of a final carry.
    always_comb begin
        carry = 1'b1;
        diff  = '0;
        for (int i = 0; i < N; i++) begin
            diff[i] = a[i] ^ b_inv[i] ^ carry;
            carry   = (a[i] & b_inv[i]) | (carry & (a[i] ^ b_inv[i]));
        end
        borrow = ~carry;
    end

endmodule

// File: rtl/serial_divider32.sv
// rtl/serial_divider32.sv - iterative unsigned restoring divider with start/busy/done handshake
module serial_divider32
    import serial_divider32_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Rem,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam logic [COUNT_BITS-1:0] LAST_ITER = COUNT_BITS'(WIDTH - 1);

    state_t                  state;
    logic [WIDTH-1:0]        dividend;
    logic [WIDTH-1:0]        divisor;
    logic [WIDTH:0]          p;
    logic [WIDTH-1:0]        quot;
    logic [COUNT_BITS-1:0]   count;

    logic [WIDTH:0]          p_shift;
    logic [WIDTH:0]          diff;
    logic                    sub_borrow;
    logic [WIDTH:0]          p_next;
    logic [WIDTH-1:0]        quot_next;
    logic                    unused_bits;

    // Bring the next dividend bit into the partial remainder.
    assign p_shift = {p[WIDTH-1:0], dividend[WIDTH-1]};

    div_subtract33 #(.N(WIDTH + 1)) u_sub (
        .a      (p_shift),
        .b      ({1'b0, divisor}),
        .diff   (diff),
        .borrow (sub_borrow)
    );

    // Restore on a negative trial difference, otherwise keep it and record a 1.
    assign p_next    = diff[WIDTH] ? p_shift : diff;
    assign quot_next = {quot[WIDTH-2:0], ~diff[WIDTH]};

    // The remainder never exceeds WIDTH bits and the sign is taken from diff.
    assign unused_bits = ^{p[WIDTH], sub_borrow};

    // Control FSM and datapath; results only move on the edge entering DONE.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            dividend  <= '0;
            divisor   <= '0;
            p         <= '0;
            quot      <= '0;
            count     <= '0;
            Q         <= '0;
            Rem       <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        if (B != '0) begin
                            dividend  <= A;
                            divisor   <= B;
                            p         <= '0;
                            quot      <= '0;
                            count     <= '0;
                            Busy      <= 1'b1;
                            DivByZero <= 1'b0;
                            state     <= RUN;
                        end else begin
                            Q         <= WIDTH'(DIV0_QUOTIENT);
                            Rem       <= A;
                            DivByZero <= 1'b1;
                            Done      <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    p        <= p_next;
                    quot     <= quot_next;
                    dividend <= {dividend[WIDTH-2:0], 1'b0};
                    count    <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        Q     <= quot_next;
                        Rem   <= p_next[WIDTH-1:0];
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_divider32.sv
// tb/tb_serial_divider32.sv - directed and back-to-back checks for serial_divider32
module tb_serial_divider32;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Q;
    logic [31:0] Rem;
    logic        Busy;
    logic        Done;
    logic        DivByZero;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs[10];

    serial_divider32 dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .A         (A),
        .B         (B),
        .Q         (Q),
        .Rem       (Rem),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // One operation from IDLE; optionally fire a stray Start with other operands mid-run.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                          input logic [31:0] er, input logic edz, input int poke);
        int          n;
        bit          busy_ok;
        bit          hold_ok;
        bit          seen;
        logic [31:0] q_before;
        logic [31:0] r_before;
        q_before = Q;
        r_before = Rem;
        Start = 1'b1;
        A = a;
        B = b;
        tick;
        Start = 1'b0;
        A = $urandom;
        B = $urandom;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        seen    = 1'b0;
        n       = 1;
        while (n <= 100 && !seen) begin
            if (n == poke) begin
                Start = 1'b1;
                A = 32'd9;
                B = 32'd3;
            end else begin
                Start = 1'b0;
            end
            if (Done) begin
                seen = 1'b1;
            end else begin
                if (Busy !== !edz) busy_ok = 1'b0;
                if (Q !== q_before || Rem !== r_before) hold_ok = 1'b0;
                tick;
                n++;
            end
        end
        Start = 1'b0;
        check("latency", 32'(n), edz ? 32'd1 : 32'd33);
        check("busy_during_run", {31'd0, busy_ok}, 32'd1);
        check("no_partial_result", {31'd0, hold_ok}, 32'd1);
        check("busy_at_done", {31'd0, Busy}, 32'd0);
        check("quotient", Q, eq);
        check("remainder", Rem, er);
        check("div_by_zero", {31'd0, DivByZero}, {31'd0, edz});
        tick;
        check("done_one_cycle", {31'd0, Done}, 32'd0);
        check("quotient_held", Q, eq);
    endtask

    logic [31:0] ca, cb, na, nb;
    logic [63:0] recon;
    int          last_done;
    int          guard;

    function automatic logic [31:0] rand_b();
        logic [31:0] v;
        v = $urandom >> $urandom_range(0, 31);
        if (v == 32'd0) v = 32'd1;
        return v;
    endfunction

    initial begin
        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1] = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
        vecs[2] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
        vecs[3] = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
        vecs[4] = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
        vecs[5] = '{32'd1000,       32'd33,         32'd30,         32'd10,         1'b0};
        vecs[6] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        vecs[7] = '{32'h80000000,   32'd2,          32'h40000000,   32'd0,          1'b0};
        vecs[8] = '{32'd12345678,   32'd1000,       32'd12345,      32'd678,        1'b0};
        vecs[9] = '{32'hDEADBEEF,   32'h00010000,   32'h0000DEAD,   32'h0000BEEF,   1'b0};

        Reset = 1'b1;
        Start = 1'b0;
        A = 32'd0;
        B = 32'd0;
        tick;
        tick;
        check("reset_q", Q, 32'd0);
        check("reset_rem", Rem, 32'd0);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_done", {31'd0, Done}, 32'd0);
        check("reset_dbz", {31'd0, DivByZero}, 32'd0);
        Reset = 1'b0;
        tick;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, 0);
        end

        // Stray Start at cycle 10 of a run must not disturb it.
        run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 10);

        // Reset in cycle 12 of a run, right after a divide by zero left flags set.
        run_op(32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 0);
        Start = 1'b1;
        A = 32'd100;
        B = 32'd7;
        tick;
        Start = 1'b0;
        for (int i = 1; i < 12; i++) tick;
        check("busy_before_reset", {31'd0, Busy}, 32'd1);
        Reset = 1'b1;
        tick;
        check("midrun_reset_q", Q, 32'd0);
        check("midrun_reset_rem", Rem, 32'd0);
        check("midrun_reset_busy", {31'd0, Busy}, 32'd0);
        check("midrun_reset_done", {31'd0, Done}, 32'd0);
        check("midrun_reset_dbz", {31'd0, DivByZero}, 32'd0);
        Reset = 1'b0;
        tick;
        run_op(32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 0);

        // Back-to-back: Start held high so each DONE cycle accepts the next pair.
        ca = $urandom;
        cb = rand_b();
        Start = 1'b1;
        A = ca;
        B = cb;
        tick;
        last_done = -1;
        for (int k = 0; k < 500; k++) begin
            na = $urandom;
            nb = rand_b();
            A = na;
            B = nb;
            Start = (k < 499);
            guard = 0;
            while (!Done && guard < 100) begin
                tick;
                guard++;
            end
            if (!Done) begin
                check("b2b_timeout", 32'd0, 32'd1);
                break;
            end
            recon = 64'(Q) * 64'(cb) + 64'(Rem);
            check("b2b_invariant", {31'd0, recon == {32'd0, ca}}, 32'd1);
            check("b2b_rem_lt_b", {31'd0, Rem < cb}, 32'd1);
            check("b2b_quotient", Q, ca / cb);
            if (last_done >= 0) check("b2b_spacing", 32'(cyc - last_done), 32'd33);
            last_done = cyc;
            ca = na;
            cb = nb;
            tick;
        end
        Start = 1'b0;
        tick;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
